// File: rtl/lsu_axi_bridge.sv
// rtl/lsu_axi_bridge.sv - load/store stage to AXI4-Lite data bus master
module lsu_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wen,
  input  logic [2:0]        i_req_func3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err,
  output logic [ADDR_W-1:0] o_araddr,
  output logic              o_arvalid,
  input  logic              i_arready,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  input  logic              i_rvalid,
  output logic              o_rready,
  output logic [ADDR_W-1:0] o_awaddr,
  output logic              o_awvalid,
  input  logic              i_awready,
  output logic [DATA_W-1:0] o_wdata,
  output logic [3:0]        o_wstrb,
  output logic              o_wvalid,
  input  logic              i_wready,
  input  logic [1:0]        i_bresp,
  input  logic              i_bvalid,
  output logic              o_bready
);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, RESP} state_t;

  state_t            state_q, state_d;
  logic [2:0]        func3_q, func3_d;
  logic [1:0]        off_q, off_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              wvalid_q, wvalid_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bready_q, bready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              accept;
  logic              illegal;
  logic              misaligned;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_ext;
  logic              rd_err;

  assign o_req_ready = (state_q == IDLE) && !rst;
  assign accept      = i_req_valid && o_req_ready;

  // Request decode and load-data alignment/extension.
  always_comb begin
    illegal    = i_req_wen ? (i_req_func3 >= 3'd3)
                           : (i_req_func3 == 3'd3 || i_req_func3 == 3'd6 || i_req_func3 == 3'd7);
    misaligned = (i_req_func3[1:0] == 2'b01 && i_req_addr[0]) ||
                 (i_req_func3[1:0] == 2'b10 && i_req_addr[1:0] != 2'b00);
    shifted    = i_rdata >> {off_q, 3'b000};
    case (func3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
    rd_err = (i_rresp != 2'b00);
  end

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    func3_d      = func3_q;
    off_d        = off_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    awaddr_d     = awaddr_q;
    wvalid_d     = wvalid_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    bready_d     = bready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          func3_d = i_req_func3;
          off_d   = i_req_addr[1:0];
          if (illegal || misaligned) begin
            // Rejected before any bus activity.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (i_req_wen) begin
            state_d   = AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = {i_req_addr[ADDR_W-1:2], 2'b00};
            case (i_req_func3[1:0])
              2'b00: begin
                wdata_d = {4{i_req_wdata[7:0]}};
                wstrb_d = 4'b0001 << i_req_addr[1:0];
              end
              2'b01: begin
                wdata_d = {2{i_req_wdata[15:0]}};
                wstrb_d = 4'b0011 << i_req_addr[1:0];
              end
              default: begin
                wdata_d = i_req_wdata;
                wstrb_d = 4'b1111;
              end
            endcase
          end else begin
            state_d   = AR;
            arvalid_d = 1'b1;
            araddr_d  = {i_req_addr[ADDR_W-1:2], 2'b00};
          end
        end
      end
      AR: begin
        if (i_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R;
        end
      end
      R: begin
        if (i_rvalid) begin
          rready_d     = 1'b0;
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = rd_err;
          resp_rdata_d = rd_err ? '0 : load_ext;
        end
      end
      AW_W: begin
        if (awvalid_q && i_awready) awvalid_d = 1'b0;
        if (wvalid_q && i_wready) wvalid_d = 1'b0;
        // Both channels done, counting any handshake landing this cycle.
        if ((!awvalid_q || i_awready) && (!wvalid_q || i_wready)) begin
          state_d  = B;
          bready_d = 1'b1;
        end
      end
      B: begin
        if (i_bvalid) begin
          bready_d     = 1'b0;
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = (i_bresp != 2'b00);
          resp_rdata_d = '0;
        end
      end
      RESP: begin
        if (i_resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any outstanding transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      func3_q      <= '0;
      off_q        <= '0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      wvalid_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      func3_q      <= func3_d;
      off_q        <= off_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      awaddr_q     <= awaddr_d;
      wvalid_q     <= wvalid_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign o_arvalid    = arvalid_q;
  assign o_araddr     = araddr_q;
  assign o_rready     = rready_q;
  assign o_awvalid    = awvalid_q;
  assign o_awaddr     = awaddr_q;
  assign o_wvalid     = wvalid_q;
  assign o_wdata      = wdata_q;
  assign o_wstrb      = wstrb_q;
  assign o_bready     = bready_q;
  assign o_resp_valid = resp_valid_q;
  assign o_resp_rdata = resp_rdata_q;
  assign o_resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// tb/tb_lsu_axi_bridge.sv - randomized self-checking bench for lsu_axi_bridge
module tb_lsu_axi_bridge;

  logic        clk, rst;
  logic        i_req_valid, o_req_ready, i_req_wen;
  logic [2:0]  i_req_func3;
  logic [31:0] i_req_addr, i_req_wdata;
  logic        o_resp_valid, i_resp_ready, o_resp_err;
  logic [31:0] o_resp_rdata;
  logic [31:0] o_araddr, i_rdata, o_awaddr, o_wdata;
  logic        o_arvalid, i_arready, i_rvalid, o_rready;
  logic [1:0]  i_rresp, i_bresp;
  logic        o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
  logic [3:0]  o_wstrb;

  int total = 0;
  int bad   = 0;

  lsu_axi_bridge dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wen(i_req_wen),
    .i_req_func3(i_req_func3), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
    .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: what a memory access should produce, from the ISA-level rules.
  function automatic void ref_model(
    input logic wen, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
    input logic [31:0] mem, input logic [1:0] resp,
    output logic bus, output logic err, output logic [31:0] rd,
    output logic [3:0] strb, output logic [31:0] lanes);
    int size, off;
    logic legal;
    longint unsigned v, span;
    size  = 1 << f3[1:0];
    off   = int'(addr[1:0]);
    legal = wen ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    bus   = legal && (off % size == 0);
    strb  = '0;
    lanes = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + size) strb[i] = 1'b1;
      lanes[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    if (!bus || resp != 2'b00) begin
      err = 1'b1; rd = '0;
    end else if (wen) begin
      err = 1'b0; rd = '0;
    end else begin
      span = 64'd1 << (8 * size);
      v = ({32'd0, mem} >> (8 * off)) % span;
      if (!f3[2] && size < 4 && v >= span / 2) v = v + (64'd1 << 32) - span;
      err = 1'b0; rd = v[31:0];
    end
  endfunction

  // Issue one request and play the AXI slave. mode: 0 zero-wait, 1 random
  // stalls with early junk R/B, 2 AW before W, 3 W before AW.
  task automatic run_txn(
    input logic wen, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
    input logic [31:0] sdata, input logic [1:0] sresp, input int mode, input int rdelay,
    output int lat, output logic [31:0] rd, output logic er,
    output logic [31:0] ara, output logic [31:0] awa, output logic [31:0] wdo, output logic [3:0] wsb,
    output int ar_seen, output int aww_seen, output int viol, output int nresp, output logic tmo);
    int cyc, w;
    logic ar_done, r_pend, r_done, aw_done, w_done, b_pend, b_issued, b_done, rsp_seen, fin, w_first;
    logic ar_hold, aw_hold, w_hold, ar_hs, aw_hs, w_hs;
    logic [31:0] ar_prev, aw_prev, wd_prev;
    logic [3:0] ws_prev;
    lat = 0; rd = '0; er = 1'b0; ara = '0; awa = '0; wdo = '0; wsb = '0;
    ar_seen = 0; aww_seen = 0; viol = 0; nresp = 0; tmo = 1'b0;
    ar_done = 0; r_pend = 0; r_done = 0; aw_done = 0; w_done = 0; b_pend = 0;
    b_issued = 0; b_done = 0; rsp_seen = 0; fin = 0; w_first = 1;
    ar_hold = 0; aw_hold = 0; w_hold = 0;
    ar_prev = '0; aw_prev = '0; wd_prev = '0; ws_prev = '0;
    w = 0;
    while (!o_req_ready && w < 50) begin @(negedge clk); w++; end
    i_req_valid = 1'b1; i_req_wen = wen; i_req_func3 = f3; i_req_addr = addr; i_req_wdata = wd;
    @(negedge clk);
    i_req_valid = 1'b0; i_req_wen = 1'($urandom); i_req_func3 = 3'($urandom);
    i_req_addr = $urandom; i_req_wdata = $urandom;
    cyc = 1;
    while (!fin && cyc < 300) begin
      if (o_arvalid) begin
        if (ar_seen == 0) ara = o_araddr;
        ar_seen++;
        if (ar_hold && o_araddr !== ar_prev) viol++;
      end else if (ar_hold) viol++;
      i_arready = (mode == 1) ? ($urandom % 3 != 0) : 1'b1;
      ar_hs   = o_arvalid && i_arready;
      ar_hold = o_arvalid && !i_arready;
      ar_prev = o_araddr;

      if (r_pend) begin
        i_rvalid = (mode == 1) ? ($urandom % 2 == 0) : 1'b1; i_rdata = sdata; i_rresp = sresp;
      end else if (mode == 1 && !r_done) begin
        i_rvalid = ($urandom % 2 == 0); i_rdata = 32'hBAD0BAD0; i_rresp = 2'b11;
      end else begin
        i_rvalid = 1'b0; i_rdata = $urandom; i_rresp = 2'b00;
      end
      if (o_rready && i_rvalid) begin
        if (!r_pend) viol++;
        r_pend = 0; r_done = 1;
      end
      if (ar_hs) begin
        if (ar_done) viol++;
        ar_done = 1; r_pend = 1;
      end

      if (o_awvalid) begin
        if (aw_prev === 32'bx || aww_seen == 0) awa = o_awaddr;
        if (aw_hold && o_awaddr !== aw_prev) viol++;
      end else if (aw_hold) viol++;
      if (o_wvalid) begin
        if (w_first) begin wdo = o_wdata; wsb = o_wstrb; w_first = 0; end
        if (w_hold && (o_wdata !== wd_prev || o_wstrb !== ws_prev)) viol++;
      end else if (w_hold) viol++;
      if (o_awvalid || o_wvalid) aww_seen++;
      case (mode)
        1: begin i_awready = ($urandom % 2 == 0); i_wready = ($urandom % 2 == 0); end
        2: begin i_awready = 1'b1; i_wready = aw_done; end
        3: begin i_awready = w_done; i_wready = 1'b1; end
        default: begin i_awready = 1'b1; i_wready = 1'b1; end
      endcase
      aw_hs   = o_awvalid && i_awready;
      w_hs    = o_wvalid && i_wready;
      aw_hold = o_awvalid && !i_awready;
      w_hold  = o_wvalid && !i_wready;
      aw_prev = o_awaddr; wd_prev = o_wdata; ws_prev = o_wstrb;

      if (b_pend) begin
        i_bvalid = (mode == 1) ? ($urandom % 2 == 0) : 1'b1; i_bresp = sresp;
      end else if (mode == 1 && !b_done) begin
        i_bvalid = ($urandom % 2 == 0); i_bresp = 2'b11;
      end else begin
        i_bvalid = 1'b0; i_bresp = 2'b00;
      end
      if (o_bready && i_bvalid) begin
        if (!b_pend) viol++;
        b_pend = 0; b_done = 1;
      end
      if (aw_hs) begin if (aw_done) viol++; aw_done = 1; end
      if (w_hs) begin if (w_done) viol++; w_done = 1; end
      if (aw_done && w_done && !b_issued) begin b_issued = 1; b_pend = 1; end

      if (o_resp_valid) begin
        if (!rsp_seen) begin
          rsp_seen = 1; lat = cyc; rd = o_resp_rdata; er = o_resp_err;
        end else if (o_resp_rdata !== rd || o_resp_err !== er) viol++;
        i_resp_ready = (cyc - lat >= rdelay);
        if (i_resp_ready) begin nresp++; fin = 1; end
      end else begin
        i_resp_ready = (mode == 1) ? ($urandom % 2 == 0) : 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (!fin) tmo = 1'b1;
    else if (o_resp_valid || !o_req_ready) viol++;
    i_arready = 0; i_rvalid = 0; i_awready = 0; i_wready = 0; i_bvalid = 0; i_resp_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req_valid = 0; i_req_wen = 0; i_req_func3 = 0; i_req_addr = 0; i_req_wdata = 0;
    i_resp_ready = 0; i_arready = 0; i_rdata = 0; i_rresp = 0; i_rvalid = 0;
    i_awready = 0; i_wready = 0; i_bresp = 0; i_bvalid = 0;
    repeat (3) @(negedge clk);
    total++;
    if (o_req_ready !== 1'b0) begin
      bad++; $display("FAIL reset_req_ready_in_rst: got %b want 0", o_req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (o_req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_req_ready: got %b want 1", o_req_ready);
    end
    total++;
    if ({o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready, o_resp_valid, o_resp_err} !== 7'd0) begin
      bad++; $display("FAIL reset_valids: got %b want 0000000",
        {o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready, o_resp_valid, o_resp_err});
    end
    total++;
    if ({o_resp_rdata, o_araddr, o_awaddr, o_wdata, o_wstrb} !== 132'd0) begin
      bad++; $display("FAIL reset_payloads: got %h want 0",
        {o_resp_rdata, o_araddr, o_awaddr, o_wdata, o_wstrb});
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [4] = '{3'b010, 3'b000, 3'b100, 3'b101};
    logic [31:0] ads [4] = '{32'h8000_0004, 32'h8000_0003, 32'h8000_0003, 32'h8000_0002};
    logic [31:0] mem [4] = '{32'hDEAD_BEEF, 32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000};
    logic [31:0] exp [4] = '{32'hDEAD_BEEF, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
    int lat, ars, aws, viol, nr;
    logic [31:0] rd, ara, awa, wdo;
    logic [3:0] wsb;
    logic er, tmo;
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b0, f3s[i], ads[i], 32'h0, mem[i], 2'b00, 0, 0,
              lat, rd, er, ara, awa, wdo, wsb, ars, aws, viol, nr, tmo);
      total++;
      if (tmo || lat !== 3) begin
        bad++; $display("FAIL load_latency[%0d]: got %0d (timeout %b) want 3", i, lat, tmo);
      end
      total++;
      if (rd !== exp[i] || er !== 1'b0) begin
        bad++; $display("FAIL load_data[%0d]: got %h err %b want %h err 0", i, rd, er, exp[i]);
      end
      total++;
      if (ara !== {ads[i][31:2], 2'b00} || aws !== 0 || viol !== 0) begin
        bad++; $display("FAIL load_bus[%0d]: got araddr %h aw/w cycles %0d viol %0d want %h 0 0",
                        i, ara, aws, viol, {ads[i][31:2], 2'b00});
      end
    end
  endtask

  task automatic test_store_order();
    logic [2:0]  f3s [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] ads [3] = '{32'h8000_0002, 32'h8000_0002, 32'h8000_0008};
    logic [31:0] wds [3] = '{32'h1234_56AB, 32'hCAFE_1234, 32'h0BAD_F00D};
    logic [31:0] ewd [3] = '{32'hABAB_ABAB, 32'h1234_1234, 32'h0BAD_F00D};
    logic [3:0]  ews [3] = '{4'b0100, 4'b1100, 4'b1111};
    int          mds [3] = '{2, 3, 0};
    int          els [3] = '{4, 4, 3};
    int lat, ars, aws, viol, nr;
    logic [31:0] rd, ara, awa, wdo;
    logic [3:0] wsb;
    logic er, tmo;
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b1, f3s[i], ads[i], wds[i], 32'h0, 2'b00, mds[i], 0,
              lat, rd, er, ara, awa, wdo, wsb, ars, aws, viol, nr, tmo);
      total++;
      if (tmo || lat !== els[i]) begin
        bad++; $display("FAIL store_latency[%0d]: got %0d (timeout %b) want %0d", i, lat, tmo, els[i]);
      end
      total++;
      if (awa !== {ads[i][31:2], 2'b00} || wdo !== ewd[i] || wsb !== ews[i]) begin
        bad++; $display("FAIL store_payload[%0d]: got %h %h %b want %h %h %b", i, awa, wdo, wsb,
                        {ads[i][31:2], 2'b00}, ewd[i], ews[i]);
      end
      total++;
      if (rd !== 0 || er !== 0 || ars !== 0 || viol !== 0) begin
        bad++; $display("FAIL store_resp[%0d]: got rdata %h err %b ar %0d viol %0d want 0 0 0 0",
                        i, rd, er, ars, viol);
      end
    end
  endtask

  task automatic test_errors();
    logic        wns [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [5] = '{3'b001, 3'b010, 3'b011, 3'b011, 3'b110};
    logic [31:0] ads [5] = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    int lat, ars, aws, viol, nr;
    logic [31:0] rd, ara, awa, wdo;
    logic [3:0] wsb;
    logic er, tmo;
    for (int i = 0; i < 5; i++) begin
      run_txn(wns[i], f3s[i], ads[i], 32'hFFFF_FFFF, 32'h1111_1111, 2'b00, 0, 0,
              lat, rd, er, ara, awa, wdo, wsb, ars, aws, viol, nr, tmo);
      total++;
      if (tmo || lat !== 1 || er !== 1'b1 || rd !== 0) begin
        bad++; $display("FAIL err_resp[%0d]: got lat %0d err %b rdata %h want 1 1 0", i, lat, er, rd);
      end
      total++;
      if (ars !== 0 || aws !== 0) begin
        bad++; $display("FAIL err_no_bus[%0d]: got ar %0d aw/w %0d want 0 0", i, ars, aws);
      end
    end
  endtask

  task automatic test_random();
    logic wen, bus, xerr, er, tmo;
    logic [2:0] f3;
    logic [31:0] addr, wd, mem, xrd, xlanes, rd, ara, awa, wdo;
    logic [1:0] resp;
    logic [3:0] xstrb, wsb;
    int lat, ars, aws, viol, nr, rdel;
    for (int n = 0; n < 60; n++) begin
      wen  = 1'($urandom);
      f3   = 3'($urandom);
      if ($urandom % 4 != 0) f3 = wen ? 3'($urandom % 3) : ((f3[2]) ? {1'b1, 1'b0, f3[0]} : {1'b0, 2'($urandom % 3)});
      addr = $urandom;
      if ($urandom % 2 == 0) addr[1:0] = 2'b00;
      wd   = $urandom;
      mem  = $urandom;
      resp = ($urandom % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rdel = (n % 6 == 0) ? 5 : int'($urandom_range(0, 5));
      ref_model(wen, f3, addr, wd, mem, resp, bus, xerr, xrd, xstrb, xlanes);
      run_txn(wen, f3, addr, wd, mem, resp, 1, rdel,
              lat, rd, er, ara, awa, wdo, wsb, ars, aws, viol, nr, tmo);
      total++;
      if (tmo || nr !== 1 || viol !== 0) begin
        bad++; $display("FAIL rnd_protocol[%0d]: got timeout %b resps %0d viol %0d want 0 1 0", n, tmo, nr, viol);
      end
      total++;
      if (rd !== xrd || er !== xerr) begin
        bad++; $display("FAIL rnd_resp[%0d]: got %h err %b want %h err %b (wen %b f3 %0d addr %h)",
                        n, rd, er, xrd, xerr, wen, f3, addr);
      end
      total++;
      if (!bus) begin
        if (lat !== 1 || ars !== 0 || aws !== 0) begin
          bad++; $display("FAIL rnd_reject[%0d]: got lat %0d ar %0d aw/w %0d want 1 0 0", n, lat, ars, aws);
        end
      end else if (wen) begin
        if (awa !== {addr[31:2], 2'b00} || wdo !== xlanes || wsb !== xstrb || ars !== 0) begin
          bad++; $display("FAIL rnd_store[%0d]: got %h %h %b ar %0d want %h %h %b 0",
                          n, awa, wdo, wsb, ars, {addr[31:2], 2'b00}, xlanes, xstrb);
        end
      end else begin
        if (ara !== {addr[31:2], 2'b00} || aws !== 0 || ars == 0) begin
          bad++; $display("FAIL rnd_load[%0d]: got araddr %h aw/w %0d ar %0d want %h 0 >0",
                          n, ara, aws, ars, {addr[31:2], 2'b00});
        end
      end
    end
  endtask

  task automatic test_bus_error();
    int lat, ars, aws, viol, nr;
    logic [31:0] rd, ara, awa, wdo;
    logic [3:0] wsb;
    logic er, tmo;
    run_txn(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h1234_5678, 2'b10, 1, 5,
            lat, rd, er, ara, awa, wdo, wsb, ars, aws, viol, nr, tmo);
    total++;
    if (tmo || er !== 1'b1 || rd !== 0 || nr !== 1 || viol !== 0) begin
      bad++; $display("FAIL rresp_err: got err %b rdata %h resps %0d viol %0d want 1 0 1 0", er, rd, nr, viol);
    end
    run_txn(1'b1, 3'b010, 32'h8000_0014, 32'h5555_AAAA, 32'h0, 2'b10, 1, 5,
            lat, rd, er, ara, awa, wdo, wsb, ars, aws, viol, nr, tmo);
    total++;
    if (tmo || er !== 1'b1 || rd !== 0 || nr !== 1 || viol !== 0) begin
      bad++; $display("FAIL bresp_err: got err %b rdata %h resps %0d viol %0d want 1 0 1 0", er, rd, nr, viol);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    w = 0;
    while (!o_req_ready && w < 50) begin @(negedge clk); w++; end
    i_req_valid = 1'b1; i_req_wen = 1'b0; i_req_func3 = 3'b010; i_req_addr = 32'h8000_0020;
    @(negedge clk);
    i_req_valid = 1'b0;
    i_arready = 1'b1;
    w = 0;
    while (!o_rready && w < 20) begin @(negedge clk); w++; end
    i_arready = 1'b0;
    total++;
    if (o_rready !== 1'b1) begin
      bad++; $display("FAIL mid_reach_r: got rready %b want 1", o_rready);
    end
    i_rvalid = 1'b1; i_rdata = 32'hCAFE_CAFE; i_rresp = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready, o_resp_valid, o_req_ready} !== 7'd0) begin
      bad++; $display("FAIL mid_reset_valids: got %b want 0000000",
        {o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready, o_resp_valid, o_req_ready});
    end
    rst = 1'b0;
    i_rvalid = 1'b0;
    @(negedge clk);
    total++;
    if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset_ready: got req_ready %b resp_valid %b want 1 0", o_req_ready, o_resp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store_order();
    test_errors();
    test_bus_error();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
